// File: rtl/intdiv_r16_ctrl_if.sv
// Handshake and status bundle between the radix-16 divider controller and its requester/datapath.
// Latency: none (wires only).
// Backpressure: start_valid_i/start_ready_o accepts requests; finish_valid_o/finish_ready_i returns results.
interface intdiv_r16_ctrl_if #(
  parameter int LZC_W = 5
);
  logic             start_valid_i;
  logic             start_ready_o;
  logic [LZC_W-1:0] dividend_lzc_i;
  logic [LZC_W-1:0] divisor_lzc_i;
  logic             divisor_zero_i;
  logic             dividend_zero_i;
  logic             finish_valid_o;
  logic             finish_ready_i;
  logic             pre_en_o;
  logic             iter_en_o;
  logic             iter_first_o;
  logic             iter_last_o;
  logic             post_en_o;
  logic [1:0]       rem_align_o;
  logic             early_finish_o;
  logic             div_zero_o;

  // Controller side
  modport slave (
    input  start_valid_i, dividend_lzc_i, divisor_lzc_i, divisor_zero_i,
           dividend_zero_i, finish_ready_i,
    output start_ready_o, finish_valid_o, pre_en_o, iter_en_o, iter_first_o,
           iter_last_o, post_en_o, rem_align_o, early_finish_o, div_zero_o
  );

  // Requester / datapath side
  modport master (
    output start_valid_i, dividend_lzc_i, divisor_lzc_i, divisor_zero_i,
           dividend_zero_i, finish_ready_i,
    input  start_ready_o, finish_valid_o, pre_en_o, iter_en_o, iter_first_o,
           iter_last_o, post_en_o, rem_align_o, early_finish_o, div_zero_o
  );
endinterface

// File: rtl/intdiv_r16_ctrl.sv
// Sequencer for the radix-16 SRT divider: IDLE -> PRE -> ITER x N -> POST -> DONE, N from operand LZCs.
// Latency: N+3 cycles normal, 3 cycles early finish, 2 cycles divide-by-zero (accept to finish_valid_o).
// Backpressure: accepts only in IDLE; holds DONE with all outputs stable until finish_ready_i.
module intdiv_r16_ctrl #(
  parameter int D_W   = 32,
  parameter int LZC_W = $clog2(D_W),
  parameter int CNT_W = $clog2(D_W / 4)
) (
  input logic              clk,
  input logic              rst,
  intdiv_r16_ctrl_if.slave bus
);

  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    PRE  = 5'b00010,
    ITER = 5'b00100,
    POST = 5'b01000,
    DONE = 5'b10000
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] iter_cnt;
  logic             first_q;
  logic             early_q;
  logic             zero_q;
  logic [1:0]       rem_align_q;
  logic [LZC_W:0]   lzc_diff;
  logic             diff_neg;
  logic             go_iter;

  // Unsigned subtraction one bit wider than the counts; the MSB is the sign.
  assign lzc_diff = {1'b0, bus.divisor_lzc_i} - {1'b0, bus.dividend_lzc_i};
  assign diff_neg = lzc_diff[LZC_W];
  assign go_iter  = (state == PRE) && (state_nxt == ITER);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state selection and output decode; outputs depend only on registered state/flags
  always_comb begin
    state_nxt          = state;
    bus.start_ready_o  = 1'b0;
    bus.finish_valid_o = 1'b0;
    bus.pre_en_o       = 1'b0;
    bus.iter_en_o      = 1'b0;
    bus.iter_first_o   = 1'b0;
    bus.iter_last_o    = 1'b0;
    bus.post_en_o      = 1'b0;
    bus.rem_align_o    = rem_align_q;
    bus.early_finish_o = early_q;
    bus.div_zero_o     = zero_q;
    case (state)
      IDLE: begin
        bus.start_ready_o = 1'b1;
        if (bus.start_valid_i) state_nxt = PRE;
      end
      PRE: begin
        bus.pre_en_o = 1'b1;
        // Divide-by-zero wins over the zero-dividend / small-dividend shortcut.
        if (bus.divisor_zero_i)                   state_nxt = DONE;
        else if (bus.dividend_zero_i || diff_neg) state_nxt = POST;
        else                                      state_nxt = ITER;
      end
      ITER: begin
        bus.iter_en_o    = 1'b1;
        bus.iter_first_o = first_q;
        bus.iter_last_o  = (iter_cnt == '0);
        if (iter_cnt == '0) state_nxt = POST;
      end
      POST: begin
        bus.post_en_o = 1'b1;
        state_nxt     = DONE;
      end
      DONE: begin
        bus.finish_valid_o = 1'b1;
        if (bus.finish_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operation context: iteration counter, alignment and result-type flags captured in PRE
  always_ff @(posedge clk) begin
    if (rst) begin
      iter_cnt    <= '0;
      first_q     <= 1'b0;
      early_q     <= 1'b0;
      zero_q      <= 1'b0;
      rem_align_q <= 2'd0;
    end else begin
      case (state)
        PRE: begin
          zero_q  <= bus.divisor_zero_i;
          early_q <= !bus.divisor_zero_i && (bus.dividend_zero_i || diff_neg);
          if (go_iter) begin
            // N-1 = lzc_diff >> 2 for a non-negative difference
            iter_cnt    <= lzc_diff[LZC_W-1:2];
            rem_align_q <= lzc_diff[1:0];
            first_q     <= 1'b1;
          end
        end
        ITER: begin
          first_q <= 1'b0;
          if (iter_cnt != '0) iter_cnt <= iter_cnt - 1'b1;
        end
        DONE: begin
          if (bus.finish_ready_i) begin
            early_q     <= 1'b0;
            zero_q      <= 1'b0;
            rem_align_q <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
